// File: rtl/decode_queue.sv
// Fetch-to-decode instruction buffer: a small circular FIFO of {pc, instr, imm, imm_type}.
// The immediate is decoded once on the write path and stored with the entry.
module decode_queue #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [31:0]                in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [31:0]                out_instr,
  output logic [XLEN-1:0]            out_imm,
  output logic [2:0]                 out_imm_type,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Handshake: a beat transfers on a rising edge when valid and ready are both
  // high; ready never depends on the other side's valid/ready in the same cycle.

  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;

  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [31:0]     mem_instr [DEPTH];
  logic [XLEN-1:0] mem_imm   [DEPTH];
  logic [2:0]      mem_type  [DEPTH];

  logic [31:0]     imm32;
  logic [2:0]      imm_type;
  logic [XLEN-1:0] wr_imm;

  always_comb begin
    imm32    = '0;
    imm_type = 3'd0;
    case (in_instr[6:0])
      7'h03, 7'h13, 7'h67: begin
        imm32    = {{20{in_instr[31]}}, in_instr[31:20]};
        imm_type = 3'd1;
      end
      7'h23: begin
        imm32    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        imm_type = 3'd2;
      end
      7'h63: begin
        imm32    = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
        imm_type = 3'd3;
      end
      7'h37, 7'h17: begin
        imm32    = {in_instr[31:12], 12'b0};
        imm_type = 3'd4;
      end
      7'h6F: begin
        imm32    = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};
        imm_type = 3'd5;
      end
      default: begin
        imm32    = '0;
        imm_type = 3'd0;
      end
    endcase
  end

  // Sign-extend the 32-bit immediate to XLEN (XLEN >= 32).
  assign wr_imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush_i;
  assign pop       = out_valid & out_ready & ~flush_i;
  assign count_o   = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset; entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]    <= in_pc;
      mem_instr[wr_ptr] <= in_instr;
      mem_imm[wr_ptr]   <= wr_imm;
      mem_type[wr_ptr]  <= imm_type;
    end
  end

  assign out_pc       = out_valid ? mem_pc[rd_ptr]    : '0;
  assign out_instr    = out_valid ? mem_instr[rd_ptr] : '0;
  assign out_imm      = out_valid ? mem_imm[rd_ptr]   : '0;
  assign out_imm_type = out_valid ? mem_type[rd_ptr]  : 3'd0;

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: directed pushes queue expected entries,
// a negedge monitor pops and compares every transfer presented by the DUT.
module tb_decode_queue;
  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] out_imm;
  logic [2:0]  out_imm_type;
  logic [1:0]  count_o;

  int checks = 0;
  int errors = 0;

  // {pc, instr, imm, imm_type}
  logic [98:0] exp_q[$];

  decode_queue #(.DEPTH(2), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_imm(out_imm), .out_imm_type(out_imm_type),
    .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a transfer is committed on the next posedge if seen here.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && !flush_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output_pc", {32'b0, out_pc}, 64'hDEAD_BEEF_DEAD_BEEF);
      end else begin
        logic [98:0] e;
        e = exp_q.pop_front();
        chk("mon_pc",    {32'b0, out_pc},       {32'b0, e[98:67]});
        chk("mon_instr", {32'b0, out_instr},    {32'b0, e[66:35]});
        chk("mon_imm",   {32'b0, out_imm},      {32'b0, e[34:3]});
        chk("mon_type",  {61'b0, out_imm_type}, {61'b0, e[2:0]});
      end
    end
  end

  // Driver: called at posedge+1, returns at posedge+1 after the accepting edge.
  task automatic push(input logic [31:0] pc, input logic [31:0] instr,
                      input logic [31:0] imm, input logic [2:0] t);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("push_timeout", 64'd1, 64'd0);
    else exp_q.push_back({pc, instr, imm, t});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; flush_i = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
    out_ready = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_in_ready",  {63'b0, in_ready},  64'd1);
    chk("rst_count",     {62'b0, count_o},   64'd0);
    chk("rst_out_pc",    {32'b0, out_pc},    64'd0);
    chk("rst_out_imm",   {32'b0, out_imm},   64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // ADDI x1,x0,-1 with 1-cycle latency
    out_ready = 1'b1;
    push(32'h100, 32'hFFF00093, 32'hFFFFFFFF, 3'd1);
    @(negedge clk);
    chk("t1_valid", {63'b0, out_valid},    64'd1);
    chk("t1_pc",    {32'b0, out_pc},       64'h100);
    chk("t1_imm",   {32'b0, out_imm},      64'hFFFFFFFF);
    chk("t1_type",  {61'b0, out_imm_type}, 64'd1);
    @(negedge clk);
    chk("t1_empty", {63'b0, out_valid},    64'd0);
    @(posedge clk); #1;

    // Fill with out_ready=0, third push held until release
    out_ready = 1'b0;
    push(32'h104, 32'hFE000EE3, 32'hFFFFFFFC, 3'd3);
    push(32'h108, 32'h123450B7, 32'h12345000, 3'd4);
    fork
      push(32'h10C, 32'h008000EF, 32'h00000008, 3'd5);
      begin
        @(negedge clk);
        chk("t2_count_full", {62'b0, count_o},  64'd2);
        chk("t2_in_ready",   {63'b0, in_ready}, 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_drain("t2_drain");

    // Streaming: 10 back-to-back ADDIs, count holds at 1
    fork
      for (int i = 0; i < 10; i++)
        push(32'h200 + 32'(4 * i), {12'(i * 3 + 1), 5'd0, 3'b000, 5'd1, 7'h13},
             32'(i * 3 + 1), 3'd1);
      begin
        @(negedge clk);
        chk("t3_count_start", {62'b0, count_o}, 64'd0);
        for (int j = 0; j < 10; j++) begin
          @(negedge clk);
          chk("t3_count_stream", {62'b0, count_o}, 64'd1);
        end
      end
    join
    wait_drain("t3_drain");

    // Flush with two entries and a concurrent push
    out_ready = 1'b0;
    push(32'h400, 32'h00500093, 32'h5, 3'd1);
    push(32'h404, 32'h00600093, 32'h6, 3'd1);
    flush_i = 1'b1; in_valid = 1'b1; in_pc = 32'h408; in_instr = 32'h00700093;
    @(posedge clk); #1;
    flush_i = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t4_count",  {62'b0, count_o},   64'd0);
    chk("t4_valid",  {63'b0, out_valid}, 64'd0);
    chk("t4_out_pc", {32'b0, out_pc},    64'd0);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("t4_still_empty", {63'b0, out_valid}, 64'd0);
    @(posedge clk); #1;

    // Unknown opcode (SYSTEM) still queued with zero immediate
    push(32'h300, 32'h00000073, 32'h0, 3'd0);
    wait_drain("t6_drain");

    // Asynchronous reset mid-cycle with one entry held
    out_ready = 1'b0;
    push(32'h500, 32'h00100093, 32'h1, 3'd1);
    chk("t5_count_pre", {62'b0, count_o}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_valid",    {63'b0, out_valid}, 64'd0);
    chk("t5_count",    {62'b0, count_o},   64'd0);
    chk("t5_in_ready", {63'b0, in_ready},  64'd1);
    chk("t5_out_pc",   {32'b0, out_pc},    64'd0);
    exp_q.delete();
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_after_valid", {63'b0, out_valid}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
